// File: rtl/uart_tx_timer_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter peripheral.
// Holds the register offsets (word address bits [1:0]), the CTRL/STATUS bit
// positions, the transmit FSM state encoding and a helper for the effective
// baud divisor.
package uart_tx_timer_periph_pkg;

  // Register offsets, decoded from Addr[1:0]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions; COUNT occupies [7:4]
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 4;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero behaves as one clock per bit
  function automatic logic [15:0] div_eff(input logic [15:0] div);
    div_eff = (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_timer_periph_fifo.sv
// uart_tx_fifo: synchronous byte FIFO holding bytes waiting to be serialised.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   push, din    - write request and byte; a push while full is accepted only
//                  when a pop happens in the same cycle
//   pop, dout    - read request; dout shows the head entry combinationally
//   count        - number of stored entries (0..FIFO_DEPTH)
//   full, empty  - occupancy flags
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(FIFO_DEPTH));
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Pointer and occupancy tracking; power-of-two depth gives natural wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_timer_periph.sv
// uart_tx_timer_periph: memory-mapped 8N1 UART transmitter behind the bridge.
// Ports:
//   clk, reset - system clock, asynchronous active-low reset
//   Addr       - word address; only Addr[1:0] selects CTRL/DIV/TXDATA/STATUS
//   WE, Din    - bridge-qualified write strobe and write data
//   Dout       - read data, combinational from Addr[1:0]
//   IRQ        - registered level interrupt: FIFO drained and line idle
//   tx         - registered serial output, idles high
module uart_tx_timer_periph
  import uart_tx_timer_periph_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          en_r;
  logic          irq_en_r;
  logic [15:0]   div_r;
  logic          ovf_r;
  tx_state_e     state_r;
  tx_state_e     state_nxt_s;
  logic [15:0]   baud_cnt_r;
  logic [15:0]   baud_nxt_s;
  logic [2:0]    bit_cnt_r;
  logic [2:0]    bit_nxt_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nxt_s;
  logic          tx_r;
  logic          tx_nxt_s;
  logic          irq_r;
  logic          pop_s;
  logic          busy_s;

  logic          wr_ctrl_s;
  logic          wr_div_s;
  logic          wr_txdata_s;
  logic          wr_status_s;
  logic          push_drop_s;

  logic [7:0]    fifo_dout_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [3:0]    count4_s;
  logic          unused_bits_s;

  assign wr_ctrl_s   = WE && (Addr[1:0] == REG_CTRL);
  assign wr_div_s    = WE && (Addr[1:0] == REG_DIV);
  assign wr_txdata_s = WE && (Addr[1:0] == REG_TXDATA);
  assign wr_status_s = WE && (Addr[1:0] == REG_STATUS);

  // A push is lost only when full and the FSM is not popping this cycle
  assign push_drop_s = wr_txdata_s && fifo_full_s && !pop_s;

  assign busy_s   = (state_r != ST_IDLE);
  assign count4_s = 4'(fifo_count_s);
  assign tx       = tx_r;
  assign IRQ      = irq_r;

  assign unused_bits_s = ^{Addr[29:2], Din[31:16]};

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata_s),
    .pop   (pop_s),
    .din   (Din[7:0]),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Software-visible control registers and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_r     <= 1'b0;
      irq_en_r <= 1'b0;
      div_r    <= DEFAULT_DIV;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        en_r     <= Din[CTRL_EN_BIT];
        irq_en_r <= Din[CTRL_IRQ_EN_BIT];
      end
      if (wr_div_s) begin
        div_r <= Din[15:0];
      end
      if (push_drop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // FSM state, baud/bit counters, shifter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_nxt_s;
      bit_cnt_r  <= bit_nxt_s;
      shift_r    <= shift_nxt_s;
      tx_r       <= tx_nxt_s;
      irq_r      <= irq_en_r & en_r & fifo_empty_s & ~busy_s;
    end
  end

  // Next-state logic; the baud counter reloads from DIV at every bit start,
  // so a DIV write only affects bit periods that begin afterwards
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_cnt_r;
    bit_nxt_s   = bit_cnt_r;
    shift_nxt_s = shift_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_r && !fifo_empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = fifo_dout_s;
          state_nxt_s = ST_START;
          baud_nxt_s  = div_eff(div_r) - 16'd1;
          bit_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_cnt_r == 16'd0) begin
          state_nxt_s = ST_DATA;
          baud_nxt_s  = div_eff(div_r) - 16'd1;
        end else begin
          baud_nxt_s = baud_cnt_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_cnt_r == 16'd0) begin
          shift_nxt_s = {1'b0, shift_r[7:1]};
          baud_nxt_s  = div_eff(div_r) - 16'd1;
          if (bit_cnt_r == 3'd7) begin
            state_nxt_s = ST_STOP;
            bit_nxt_s   = 3'd0;
          end else begin
            bit_nxt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          baud_nxt_s = baud_cnt_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_cnt_r == 16'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          baud_nxt_s = baud_cnt_r - 16'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from the next state so the
  // start bit appears right after the pop edge
  always_comb begin
    tx_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_START: tx_nxt_s = 1'b0;
      ST_DATA:  tx_nxt_s = shift_nxt_s[0];
      default:  tx_nxt_s = 1'b1;
    endcase
  end

  // Read-data multiplexer
  always_comb begin
    Dout = 32'd0;
    case (Addr[1:0])
      REG_CTRL:   Dout = {30'd0, irq_en_r, en_r};
      REG_DIV:    Dout = {16'd0, div_r};
      REG_TXDATA: Dout = 32'd0;
      REG_STATUS: Dout = {24'd0, count4_s, ovf_r, busy_s, fifo_full_s, fifo_empty_s};
      default:    Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_timer_periph.sv
// Directed self-checking bench for uart_tx_timer_periph (FIFO_DEPTH=4).
module tb_uart_tx_timer_periph;

  logic        clk;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        tx;

  int total = 0;
  int bad   = 0;

  uart_tx_timer_periph #(
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One register write, taking effect on the next rising edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'd0, a};
    #1;
    d = Dout;
  endtask

  // Called one step after the pop edge; checks a full frame cycle by cycle
  // and then the mandatory idle cycle that follows it
  task automatic frame(input string tag, input logic [7:0] b, input int d);
    logic e;
    int   k;
    Addr = 30'd3;
    #1;
    for (int c = 0; c < 10 * d; c++) begin
      k = c / d;
      if (k == 0)
        e = 1'b0;
      else if (k <= 8)
        e = b[k-1];
      else
        e = 1'b1;
      chk({tag, "_tx"}, {31'd0, tx}, {31'd0, e});
      chk({tag, "_busy"}, {31'd0, Dout[2]}, 32'd1);
      chk({tag, "_irq"}, {31'd0, IRQ}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
    chk({tag, "_idle_busy"}, {31'd0, Dout[2]}, 32'd0);
    chk({tag, "_idle_irq"}, {31'd0, IRQ}, 32'd0);
  endtask

  logic [31:0] rdata;

  initial begin
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = 30'd0;
    Din   = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    reset = 1'b1;
    rd(2'd0, rdata); chk("rst_ctrl", rdata, 32'h0);
    rd(2'd1, rdata); chk("rst_div", rdata, 32'd434);
    rd(2'd3, rdata); chk("rst_status", rdata, 32'h1);
    rd(2'd2, rdata); chk("txdata_reads0", rdata, 32'h0);

    // Single frame 0xA5, DIV=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    wr(2'd2, 32'hA5);
    chk("lat_tx_still_high", {31'd0, tx}, 32'd1);
    rd(2'd3, rdata); chk("lat_status_count1", rdata, 32'h10);
    @(posedge clk);
    #1;
    frame("a5", 8'hA5, 2);
    rd(2'd3, rdata); chk("a5_status_after", rdata, 32'h1);

    // Overflow with EN=0, then drain four frames back-to-back
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h11);
    wr(2'd2, 32'h22);
    wr(2'd2, 32'h33);
    wr(2'd2, 32'h44);
    wr(2'd2, 32'h55);
    rd(2'd3, rdata); chk("ovf_status", rdata, 32'h4A);
    wr(2'd3, 32'h0);
    rd(2'd3, rdata); chk("ovf_cleared", rdata, 32'h42);
    wr(2'd0, 32'h1);
    chk("en_tx_high", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    frame("f11", 8'h11, 2);
    @(posedge clk);
    #1;
    frame("f22", 8'h22, 2);
    @(posedge clk);
    #1;
    frame("f33", 8'h33, 2);
    @(posedge clk);
    #1;
    frame("f44", 8'h44, 2);
    @(posedge clk);
    #1;
    chk("drain_tx_idle", {31'd0, tx}, 32'd1);
    rd(2'd3, rdata); chk("drain_status", rdata, 32'h1);

    // Interrupt behaviour, DIV=1
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h3);
    chk("irq_lag", {31'd0, IRQ}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_set", {31'd0, IRQ}, 32'd1);
    wr(2'd2, 32'h00);
    chk("irq_held_at_push", {31'd0, IRQ}, 32'd1);
    @(posedge clk);
    #1;
    frame("f00", 8'h00, 1);
    @(posedge clk);
    #1;
    chk("irq_after_frame", {31'd0, IRQ}, 32'd1);
    wr(2'd2, 32'h3C);
    chk("irq_push_lag", {31'd0, IRQ}, 32'd1);
    @(posedge clk);
    #1;
    frame("f3c", 8'h3C, 1);

    // DIV=0 behaves as one clock per bit
    wr(2'd1, 32'd0);
    rd(2'd1, rdata); chk("div0_read", rdata, 32'h0);
    wr(2'd2, 32'hFF);
    @(posedge clk);
    #1;
    frame("fff", 8'hFF, 1);

    // Asynchronous reset in the middle of a data bit
    wr(2'd1, 32'd4);
    wr(2'd2, 32'h00);
    @(posedge clk);
    #1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("mid_data_tx_low", {31'd0, tx}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, tx}, 32'd1);
    chk("async_rst_irq", {31'd0, IRQ}, 32'd0);
    @(posedge clk);
    #1;
    rd(2'd3, rdata); chk("rst_status_idle", rdata, 32'h1);
    reset = 1'b1;
    rd(2'd1, rdata); chk("rst_div_back", rdata, 32'd434);
    rd(2'd0, rdata); chk("rst_ctrl_back", rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_tx", {31'd0, tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_timer_periph.md
Name: uart_tx_timer_periph

Overview:
- Memory-mapped UART transmitter peripheral on the bridge's device side, in the same slot and with the same bus interface as the timer counters.
- The CPU writes bytes through the bridge into a small TX FIFO. A baud-rate state machine serialises them (8N1, LSB first) onto a single output line.
- Raises a level interrupt, routed into an HWInt bit, when the FIFO drains.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2.
- DEFAULT_DIV, 16'd434, reset value of the DIV register; clocks per bit.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- Addr  input  30  word address from the bridge; only Addr[1:0] decoded (byte offsets 0x0/0x4/0x8/0xC).
- WE  input  1  write strobe, already qualified by the bridge for this device's range.
- Din  input  32  write data.
- Dout  output  32  read data, combinational from Addr[1:0].
- IRQ  output  1  level interrupt request.
- tx  output  1  serial line, idles high.

Behaviour:
- Register map (Addr[1:0]):
  - 0 CTRL, R/W: bit0 EN, bit1 IRQ_EN; other bits read 0.
  - 1 DIV, R/W: bits[15:0]; upper bits read 0.
  - 2 TXDATA, W: pushes Din[7:0]; reads return 0.
  - 3 STATUS, R: bit0 EMPTY, bit1 FULL, bit2 BUSY, bit3 OVF, bits[7:4] COUNT. Any write to STATUS clears OVF.
- Reset (reset=0, asynchronous):
  - CTRL=0, DIV=DEFAULT_DIV, FIFO empty, OVF=0, FSM=IDLE, baud/bit counters=0.
  - tx=1 and IRQ=0 immediately, including mid-frame.
- All register updates occur on the rising clk edge when WE=1.
- FIFO:
  - Push on WE && Addr[1:0]==2.
  - Push while FULL is dropped and sets OVF (sticky); FIFO contents and COUNT are unchanged.
  - Simultaneous push and pop on a non-full FIFO: COUNT unchanged, both take effect.
  - Simultaneous push and pop on a full FIFO: the push is accepted, because the pop frees a slot in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If EN=1 and FIFO not empty, pop into the shift register and go to START on that edge.
  - START: tx=0 for DIVeff cycles, then DATA.
  - DATA: tx=shift[0] for DIVeff cycles per bit, shifting right; after 8 bits go to STOP.
  - STOP: tx=1 for DIVeff cycles, then IDLE.
  - DIVeff = (DIV==0) ? 1 : DIV.
  - Frame length is exactly 10×DIVeff cycles, plus at least 1 IDLE cycle between frames.
- DIV is sampled by the baud counter on each bit-period start. A write mid-frame affects only subsequent bit periods.
- Clearing EN mid-frame completes the current frame; no further pops occur.
- BUSY=1 whenever FSM≠IDLE.
- IRQ = IRQ_EN & EN & EMPTY & ~BUSY, registered, so it asserts one cycle after the condition becomes true and deasserts one cycle after a push or a CTRL clear.
- Latency: a push at edge n to an idle, enabled device produces the pop at edge n+1, and tx goes low after edge n+1.

Decomposition:
- Shared package holds:
  - register offsets (REG_CTRL=0, REG_DIV=1, REG_TXDATA=2, REG_STATUS=3);
  - STATUS/CTRL bit positions;
  - FSM state encoding (2 bits: IDLE=0, START=1, DATA=2, STOP=3).
- One natural sub-module: uart_tx_fifo, a synchronous FIFO. It has push/pop/din/dout/count/full/empty outputs and a parameter FIFO_DEPTH.

Test Plan:
- Reset → tx=1, IRQ=0, Dout@CTRL=0, Dout@DIV=434, Dout@STATUS=0x1 (EMPTY).
- CTRL=1, DIV=2, push 0xA5 → tx low after edge n+1 for 2 cycles, then bits 1,0,1,0,0,1,0,1 at 2 cycles each, stop high 2 cycles; 20-cycle frame; BUSY high throughout.
- EN=0, push 5 bytes with FIFO_DEPTH=4 → STATUS COUNT=4, FULL=1, OVF=1; write STATUS → OVF=0, COUNT still 4. Then set EN=1 → 4 frames sent back-to-back, each separated by 1 IDLE cycle.
- CTRL=3, DIV=1, push 0x00 → IRQ=0 during frame; IRQ=1 one cycle after return to IDLE with EMPTY; a new push deasserts IRQ the next cycle.
- DIV=0, push 0xFF → 10-cycle frame (DIVeff=1).
- Assert reset mid-DATA → tx=1 and IRQ=0 asynchronously. After release: FSM IDLE, FIFO empty, DIV=434.
